// File: rtl/sequencer_pkg.sv
// sequencer_pkg
//   Shared types and constants for the cell array sequencer.
//   - seq_state_e : sequencer FSM states
//   - err_code_e  : abort reason reported with done
//   - Op*         : flow-control opcodes found in instruction[15:12]
package sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFetch = 2'd1,
      StExec  = 2'd2,
      StDone  = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      ErrNone      = 2'd0,
      ErrOverflow  = 2'd1,
      ErrUnderflow = 2'd2,
      ErrTimeout   = 2'd3
   } err_code_e;

   localparam logic [3:0] OpJmp  = 4'hC;
   localparam logic [3:0] OpCall = 4'hD;
   localparam logic [3:0] OpRet  = 4'hE;
   localparam logic [3:0] OpHalt = 4'hF;

endpackage

// File: rtl/seq_return_stack.sv
// seq_return_stack
//   Return-address stack of 2**SP_LENGTH x PC_LENGTH registers.
//   Ports:
//     clk, rst      : clock, asynchronous active-low reset
//     clear_i       : synchronous pointer clear (start of a frame)
//     push_i        : push push_data_i (ignored when full)
//     pop_i         : pop one entry (ignored when empty)
//     sp_o          : current stack pointer (number of live entries)
//     top_o         : most recently pushed entry
//     full_o        : pointer at its maximum, further pushes would wrap it
//     empty_o       : no live entries
module seq_return_stack #(
   parameter int unsigned PC_LENGTH = 12,
   parameter int unsigned SP_LENGTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear_i,
   input  logic                 push_i,
   input  logic                 pop_i,
   input  logic [PC_LENGTH-1:0] push_data_i,
   output logic [SP_LENGTH-1:0] sp_o,
   output logic [PC_LENGTH-1:0] top_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int unsigned Depth = 2 ** SP_LENGTH;

   logic [SP_LENGTH-1:0] sp_q, sp_d;
   logic [PC_LENGTH-1:0] mem_q [Depth];
   logic                 push_ok;
   logic                 pop_ok;

   // Full is declared one entry early so the pointer itself never wraps;
   // the highest slot is therefore never written.
   assign full_o  = (sp_q == {SP_LENGTH{1'b1}});
   assign empty_o = (sp_q == '0);
   assign push_ok = push_i & ~full_o & ~clear_i;
   assign pop_ok  = pop_i & ~empty_o & ~clear_i;

   always_comb begin
      sp_d = sp_q;
      if (clear_i) begin
         sp_d = '0;
      end else if (push_ok) begin
         sp_d = sp_q + SP_LENGTH'(1);
      end else if (pop_ok) begin
         sp_d = sp_q - SP_LENGTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp_q <= '0;
      end else begin
         sp_q <= sp_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_ok) begin
         mem_q[sp_q] <= push_data_i;
      end
   end

   assign sp_o  = sp_q;
   assign top_o = mem_q[sp_q - SP_LENGTH'(1)];

endmodule

// File: rtl/cell_array_sequencer.sv
// cell_array_sequencer
//   Fetches a frame program from instruction memory and broadcasts each
//   instruction, with the post-instruction PC and SP, to an array of cell
//   cores. Handles JMP/CALL/RET/HALT itself and aborts on stack overflow,
//   stack underflow, cell divergence or an exhausted step budget.
//   Ports:
//     clk, rst                 : clock, asynchronous active-low reset
//     start                    : begins one frame (only accepted when idle)
//     busy                     : frame running (FETCH or EXEC)
//     done                     : one-cycle end-of-frame pulse
//     error, err_code          : abort flag and reason, valid with done
//     imem_addr, imem_rd_en    : instruction memory read request
//     imem_data                : instruction word, one cycle after the read
//     instruction              : word broadcast to the cells
//     next_program_counter     : post-instruction PC broadcast to the cells
//     next_stack_pointer       : post-instruction SP broadcast to the cells
//     execution_enable         : cell execute strobe
//     diverge_any              : OR of all cell diverge flags
//     frame_count              : completed error-free frames (wrapping)
module cell_array_sequencer
   import sequencer_pkg::*;
#(
   parameter int unsigned PC_LENGTH = 12,
   parameter int unsigned SP_LENGTH = 5,
   parameter int unsigned MAX_STEPS = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [1:0]           err_code,
   output logic [PC_LENGTH-1:0] imem_addr,
   output logic                 imem_rd_en,
   input  logic [15:0]          imem_data,
   output logic [15:0]          instruction,
   output logic [PC_LENGTH-1:0] next_program_counter,
   output logic [SP_LENGTH-1:0] next_stack_pointer,
   output logic                 execution_enable,
   input  logic                 diverge_any,
   output logic [15:0]          frame_count
);

   localparam int unsigned StepW = $clog2(MAX_STEPS + 1);
   localparam logic [StepW-1:0] MaxStepsW = StepW'(MAX_STEPS);

   seq_state_e           state_q, state_d;
   logic [PC_LENGTH-1:0] pc_q, pc_d;
   logic [StepW-1:0]     step_q, step_d;
   logic [15:0]          instr_q, instr_d;
   logic                 exec_en_q, exec_en_d;
   logic [PC_LENGTH-1:0] npc_q, npc_d;
   logic [SP_LENGTH-1:0] nsp_q, nsp_d;
   logic                 error_q, error_d;
   err_code_e            err_code_q, err_code_d;
   logic [15:0]          frame_count_q, frame_count_d;

   logic                 stk_clear;
   logic                 stk_push;
   logic                 stk_pop;
   logic [SP_LENGTH-1:0] stk_sp;
   logic [PC_LENGTH-1:0] stk_top;
   logic                 stk_full;
   logic                 stk_empty;

   logic [3:0]           op;
   logic [PC_LENGTH-1:0] jump_target;
   logic [PC_LENGTH-1:0] pc_inc;
   logic [StepW-1:0]     step_inc;
   logic [PC_LENGTH-1:0] exec_npc;
   logic [SP_LENGTH-1:0] exec_nsp;
   logic                 hard_abort;
   err_code_e            hard_code;
   logic                 halt;
   logic                 late_diverge;

   seq_return_stack #(
      .PC_LENGTH(PC_LENGTH),
      .SP_LENGTH(SP_LENGTH)
   ) u_stack (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (stk_clear),
      .push_i     (stk_push),
      .pop_i      (stk_pop),
      .push_data_i(pc_inc),
      .sp_o       (stk_sp),
      .top_o      (stk_top),
      .full_o     (stk_full),
      .empty_o    (stk_empty)
   );

   // The word being executed is decoded straight from the memory port in
   // EXEC; instr_q is its registered copy broadcast to the cells.
   assign op          = imem_data[15:12];
   assign jump_target = PC_LENGTH'(imem_data[11:0]);
   assign pc_inc      = pc_q + PC_LENGTH'(1);
   assign step_inc    = step_q + StepW'(1);

   // The cells execute the last instruction of a frame during DONE, so a
   // divergence there must still be reported with this done pulse. An
   // earlier error is kept.
   assign late_diverge = (state_q == StDone) && exec_en_q && diverge_any && !error_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      step_d        = step_q;
      instr_d       = instr_q;
      exec_en_d     = 1'b0;
      npc_d         = npc_q;
      nsp_d         = nsp_q;
      error_d       = error_q;
      err_code_d    = err_code_q;
      frame_count_d = frame_count_q;
      stk_clear     = 1'b0;
      stk_push      = 1'b0;
      stk_pop       = 1'b0;
      exec_npc      = pc_inc;
      exec_nsp      = stk_sp;
      hard_abort    = 1'b0;
      hard_code     = ErrNone;
      halt          = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StFetch;
               pc_d       = '0;
               step_d     = '0;
               error_d    = 1'b0;
               err_code_d = ErrNone;
               stk_clear  = 1'b1;
            end
         end

         StFetch: begin
            // exec_en_q high here means the cells ran the previous word in
            // this cycle, so diverge_any reflects that instruction.
            if (exec_en_q && diverge_any) begin
               state_d    = StDone;
               error_d    = 1'b1;
               err_code_d = ErrUnderflow;
            end else begin
               state_d = StExec;
            end
         end

         StExec: begin
            instr_d = imem_data;
            step_d  = step_inc;

            case (op)
               OpJmp: exec_npc = jump_target;
               OpCall: begin
                  if (stk_full) begin
                     hard_abort = 1'b1;
                     hard_code  = ErrOverflow;
                  end else begin
                     stk_push = 1'b1;
                     exec_npc = jump_target;
                     exec_nsp = stk_sp + SP_LENGTH'(1);
                  end
               end
               OpRet: begin
                  if (stk_empty) begin
                     hard_abort = 1'b1;
                     hard_code  = ErrUnderflow;
                  end else begin
                     stk_pop  = 1'b1;
                     exec_npc = stk_top;
                     exec_nsp = stk_sp - SP_LENGTH'(1);
                  end
               end
               OpHalt:  halt = 1'b1;
               default: ;
            endcase

            if (hard_abort) begin
               // Faulting stack operations are never shown to the cells.
               state_d    = StDone;
               error_d    = 1'b1;
               err_code_d = hard_code;
            end else begin
               exec_en_d = 1'b1;
               pc_d      = exec_npc;
               npc_d     = exec_npc;
               nsp_d     = exec_nsp;
               if (halt) begin
                  state_d = StDone;
               end else if (step_inc == MaxStepsW) begin
                  state_d    = StDone;
                  error_d    = 1'b1;
                  err_code_d = ErrTimeout;
               end else begin
                  state_d = StFetch;
               end
            end
         end

         StDone: begin
            state_d = StIdle;
            if (late_diverge) begin
               error_d    = 1'b1;
               err_code_d = ErrUnderflow;
            end
            if (!(error_q || late_diverge)) begin
               frame_count_d = frame_count_q + 16'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         pc_q          <= '0;
         step_q        <= '0;
         instr_q       <= '0;
         exec_en_q     <= 1'b0;
         npc_q         <= '0;
         nsp_q         <= '0;
         error_q       <= 1'b0;
         err_code_q    <= ErrNone;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         step_q        <= step_d;
         instr_q       <= instr_d;
         exec_en_q     <= exec_en_d;
         npc_q         <= npc_d;
         nsp_q         <= nsp_d;
         error_q       <= error_d;
         err_code_q    <= err_code_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign busy                 = (state_q == StFetch) || (state_q == StExec);
   assign done                 = (state_q == StDone);
   assign error                = error_q | late_diverge;
   assign err_code             = late_diverge ? ErrUnderflow : err_code_q;
   assign imem_rd_en           = (state_q == StFetch);
   assign imem_addr            = (state_q == StFetch) ? pc_q : '0;
   assign instruction          = instr_q;
   assign next_program_counter = npc_q;
   assign next_stack_pointer   = nsp_q;
   assign execution_enable     = exec_en_q;
   assign frame_count          = frame_count_q;

endmodule

// File: tb/tb_cell_array_sequencer.sv
// tb_cell_array_sequencer
//   Scoreboard bench: each test loads a program, pushes the expected fetch,
//   execute and done events, then runs the frame; a monitor pops and checks
//   an event each time the DUT shows one.
module tb_cell_array_sequencer;

   localparam int unsigned PcW        = 12;
   localparam int unsigned SpW        = 5;
   localparam int unsigned TbMaxSteps = 40;

   localparam int EvFetch = 0;
   localparam int EvExec  = 1;
   localparam int EvDone  = 2;

   typedef struct {
      int kind;
      int a;
      int b;
      int c;
   } ev_t;

   logic           clk;
   logic           rst;
   logic           start;
   logic           busy;
   logic           done;
   logic           error;
   logic [1:0]     err_code;
   logic [PcW-1:0] imem_addr;
   logic           imem_rd_en;
   logic [15:0]    imem_data;
   logic [15:0]    instruction;
   logic [PcW-1:0] next_program_counter;
   logic [SpW-1:0] next_stack_pointer;
   logic           execution_enable;
   logic           diverge_any;
   logic [15:0]    frame_count;

   logic [15:0] mem [0:4095];
   ev_t         exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic        mon_en = 1'b0;

   cell_array_sequencer #(
      .PC_LENGTH(PcW),
      .SP_LENGTH(SpW),
      .MAX_STEPS(TbMaxSteps)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .busy                (busy),
      .done                (done),
      .error               (error),
      .err_code            (err_code),
      .imem_addr           (imem_addr),
      .imem_rd_en          (imem_rd_en),
      .imem_data           (imem_data),
      .instruction         (instruction),
      .next_program_counter(next_program_counter),
      .next_stack_pointer  (next_stack_pointer),
      .execution_enable    (execution_enable),
      .diverge_any         (diverge_any),
      .frame_count         (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: data valid the cycle after the read strobe.
   initial imem_data = 16'h0000;
   always @(posedge clk) begin
      if (imem_rd_en) imem_data <= mem[imem_addr];
   end

   task automatic cmp(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void exp_push(input int kind, input int a, input int b, input int c);
      ev_t e;
      e.kind = kind;
      e.a    = a;
      e.b    = b;
      e.c    = c;
      exp_q.push_back(e);
   endfunction

   task automatic check_ev(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL unexpected_event: got kind %0d expected none", kind);
         return;
      end
      e = exp_q.pop_front();
      cmp("event_kind", kind, e.kind);
      if (e.kind == kind) begin
         if (kind == EvFetch) begin
            cmp("imem_addr", imem_addr, e.a);
         end else if (kind == EvExec) begin
            cmp("next_program_counter", next_program_counter, e.a);
            cmp("next_stack_pointer", next_stack_pointer, e.b);
            cmp("instruction", instruction, e.c);
         end else begin
            cmp("done_error", error, e.a);
            cmp("done_err_code", err_code, e.b);
            cmp("done_frame_count", frame_count, e.c);
         end
      end
   endtask

   // Same-cycle events are consumed in the order execute, fetch, done.
   always @(negedge clk) begin
      if (mon_en && rst) begin
         if (execution_enable) check_ev(EvExec);
         if (imem_rd_en) check_ev(EvFetch);
         if (done) check_ev(EvDone);
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
   endtask

   task automatic check_zero_outputs(input string tag);
      cmp({tag, "_busy"}, busy, 0);
      cmp({tag, "_done"}, done, 0);
      cmp({tag, "_error"}, error, 0);
      cmp({tag, "_err_code"}, err_code, 0);
      cmp({tag, "_imem_addr"}, imem_addr, 0);
      cmp({tag, "_imem_rd_en"}, imem_rd_en, 0);
      cmp({tag, "_instruction"}, instruction, 0);
      cmp({tag, "_next_pc"}, next_program_counter, 0);
      cmp({tag, "_next_sp"}, next_stack_pointer, 0);
      cmp({tag, "_exec_en"}, execution_enable, 0);
      cmp({tag, "_frame_count"}, frame_count, 0);
   endtask

   // exp_cycles < 0 skips the latency check. poke_start re-pulses start
   // mid-frame; div_once raises diverge_any alongside the first exec pulse.
   task automatic run_frame(input int exp_cycles, input bit poke_start, input bit div_once);
      int cycles;
      bit div_done;
      cycles   = 0;
      div_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!done && cycles < 400) begin
         @(negedge clk);
         cycles++;
         start = poke_start && (cycles == 2);
         if (div_once && execution_enable && !div_done) begin
            diverge_any = 1'b1;
            div_done    = 1'b1;
         end else begin
            diverge_any = 1'b0;
         end
      end
      diverge_any = 1'b0;
      start       = 1'b0;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: got no done expected done within 400 cycles");
      end else if (exp_cycles >= 0) begin
         cmp("done_latency", cycles, exp_cycles);
      end
      @(posedge clk);
      #1;
      cmp("scoreboard_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic load_and_expect_nop_halt(input int fc_before);
      clear_mem();
      mem[0] = 16'h0000;
      mem[1] = 16'h1234;
      mem[2] = 16'hF000;
      exp_push(EvFetch, 0, 0, 0);
      exp_push(EvExec, 1, 0, 16'h0000);
      exp_push(EvFetch, 1, 0, 0);
      exp_push(EvExec, 2, 0, 16'h1234);
      exp_push(EvFetch, 2, 0, 0);
      exp_push(EvExec, 3, 0, 16'hF000);
      exp_push(EvDone, 0, 0, fc_before);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      rst         = 1'b0;
      start       = 1'b0;
      diverge_any = 1'b0;
      clear_mem();
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst    = 1'b1;
      mon_en = 1'b1;

      // NOP, NOP, HALT: three execs at pc 0..2, done six cycles into the frame
      load_and_expect_nop_halt(0);
      run_frame(6, 1'b0, 1'b0);
      cmp("t1_frame_count", frame_count, 1);
      cmp("t1_error", error, 0);

      // CALL 5 / RET / HALT, with a stray start pulse that must be ignored
      clear_mem();
      mem[0] = 16'hD005;
      mem[1] = 16'hF000;
      mem[5] = 16'hE000;
      exp_push(EvFetch, 0, 0, 0);
      exp_push(EvExec, 5, 1, 16'hD005);
      exp_push(EvFetch, 5, 0, 0);
      exp_push(EvExec, 1, 0, 16'hE000);
      exp_push(EvFetch, 1, 0, 0);
      exp_push(EvExec, 2, 0, 16'hF000);
      exp_push(EvDone, 0, 0, 1);
      run_frame(-1, 1'b1, 1'b0);
      cmp("t2_frame_count", frame_count, 2);

      // RET on an empty stack: underflow, no exec pulse
      clear_mem();
      mem[0] = 16'hE000;
      exp_push(EvFetch, 0, 0, 0);
      exp_push(EvDone, 1, 2, 2);
      run_frame(-1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      cmp("t3_error_held", error, 1);
      cmp("t3_err_code_held", err_code, 2);
      cmp("t3_frame_count", frame_count, 2);

      // Recursive CALL 0: 31 pushes then overflow
      clear_mem();
      mem[0] = 16'hD000;
      exp_push(EvFetch, 0, 0, 0);
      for (int k = 1; k <= 31; k++) begin
         exp_push(EvExec, 0, k, 16'hD000);
         exp_push(EvFetch, 0, 0, 0);
      end
      exp_push(EvDone, 1, 1, 2);
      run_frame(-1, 1'b0, 1'b0);
      cmp("t4_frame_count", frame_count, 2);

      // JMP 0 forever: step budget runs out, last word still executes
      clear_mem();
      mem[0] = 16'hC000;
      exp_push(EvFetch, 0, 0, 0);
      for (int k = 1; k < int'(TbMaxSteps); k++) begin
         exp_push(EvExec, 0, 0, 16'hC000);
         exp_push(EvFetch, 0, 0, 0);
      end
      exp_push(EvExec, 0, 0, 16'hC000);
      exp_push(EvDone, 1, 3, 2);
      run_frame(-1, 1'b0, 1'b0);
      cmp("t5_frame_count", frame_count, 2);

      // JMP 0 with a cell diverging on the first exec
      exp_push(EvFetch, 0, 0, 0);
      exp_push(EvExec, 0, 0, 16'hC000);
      exp_push(EvFetch, 0, 0, 0);
      exp_push(EvDone, 1, 2, 2);
      run_frame(-1, 1'b0, 1'b1);
      cmp("t6_frame_count", frame_count, 2);

      // Reset in the middle of EXEC: everything clears, no done pulse
      mon_en = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      cmp("t7_busy_before_reset", busy, 1);
      rst = 1'b0;
      #1;
      check_zero_outputs("midreset");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         cmp("t7_no_done", done, 0);
      end
      rst = 1'b1;
      @(negedge clk);
      cmp("t7_done_after_release", done, 0);
      mon_en = 1'b1;

      // A normal frame after the reset
      load_and_expect_nop_halt(0);
      run_frame(6, 1'b0, 1'b0);
      cmp("t8_frame_count", frame_count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
